all_things_mem_tester: RTL

Avalon-MM initiator that exercises the 32-bit single-port on-chip RAM slave in the `all_things` system: on `start` it writes an address-derived pattern to a window of words, reads the window back, and compares. It sits on the same interconnect as the Nios/console masters. Its `pass`, `err_count` and `first_err_addr` results are exposed for a status PIO or the console.

---
 rtl/all_things_mem_tester_pkg.sv | 16 +
 rtl/all_things_mem_tester_if.sv | 30 +++
 rtl/all_things_mem_tester_rd_pipe.sv | 68 ++++++
 rtl/all_things_mem_tester.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/all_things_mem_tester_pkg.sv
// Shared types and constants for the all_things RAM tester.
package all_things_mem_tester_pkg;

    // Width of the saturating mismatch counter.
    localparam int ERR_CNT_W = 16;

    // Tester FSM states; also exported on the debug state port.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/all_things_mem_tester_if.sv
// Avalon-MM bus between the tester (master) and the on-chip RAM (slave).
//
// Handshake: a transfer happens on a cycle where (read | write) is high and
// waitrequest is low. While waitrequest is high the master keeps address,
// writedata, read and write unchanged. read and write are never high together,
// and chipselect is high exactly when one of them is. Read data returns a
// fixed number of cycles after the read is accepted.
interface all_things_mem_tester_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                chipselect;
    logic                write;
    logic                read;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W-1:0]   readdata;
    logic                waitrequest;

    modport master (
        output address, byteenable, chipselect, write, read, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, byteenable, chipselect, write, read, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/all_things_mem_tester_rd_pipe.sv
// Fixed-latency tracking pipe: each accepted read pushes its expected data and
// address, which emerge DEPTH cycles later alongside the returned readdata.
module all_things_rd_pipe #(
    parameter int DEPTH  = 1,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_exp,
    input  logic [ADDR_W-1:0] push_addr,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_exp,
    output logic [ADDR_W-1:0] out_addr,
    output logic              empty
);

    logic              vld_q  [DEPTH];
    logic              vld_d  [DEPTH];
    logic [DATA_W-1:0] exp_q  [DEPTH];
    logic [DATA_W-1:0] exp_d  [DEPTH];
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];

    // Shift every stage one place toward the output; stage 0 takes the new push.
    always_comb begin
        vld_d[0]  = push;
        exp_d[0]  = push_exp;
        addr_d[0] = push_addr;
        for (int i = 1; i < DEPTH; i++) begin
            vld_d[i]  = vld_q[i-1];
            exp_d[i]  = exp_q[i-1];
            addr_d[i] = addr_q[i-1];
        end
    end

    // Pipe registers, cleared by reset so no stale entry survives a reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                vld_q[i]  <= 1'b0;
                exp_q[i]  <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                vld_q[i]  <= vld_d[i];
                exp_q[i]  <= exp_d[i];
                addr_q[i] <= addr_d[i];
            end
        end
    end

    // The last stage is the entry whose readdata is on the bus this cycle.
    // "empty" means nothing remains behind it, so the pipe is drained once the
    // current output has been compared.
    always_comb begin
        out_valid = vld_q[DEPTH-1];
        out_exp   = exp_q[DEPTH-1];
        out_addr  = addr_q[DEPTH-1];
        empty     = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (vld_q[i]) empty = 1'b0;
        end
    end

endmodule

// File: rtl/all_things_mem_tester.sv
// Avalon-MM memory tester: writes (seed + i) to (base + i) for a window of
// words, reads them back through a fixed-latency pipe and counts mismatches.
module all_things_mem_tester
    import all_things_mem_tester_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W:0]      length,
    input  logic [DATA_W-1:0]    seed,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [ADDR_W-1:0]    first_err_addr,
    output state_t               dbg_state,
    all_things_mem_tester_if.master avm
);

    localparam logic [ADDR_W:0]      IDX_ONE = 1;
    localparam logic [ERR_CNT_W-1:0] ERR_ONE = 1;

    state_t               state_q, state_d;
    logic [ADDR_W:0]      idx_q, idx_d;
    logic [ADDR_W:0]      len_q, len_d;
    logic [ADDR_W-1:0]    base_q, base_d;
    logic [DATA_W-1:0]    seed_q, seed_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic [ADDR_W-1:0]    first_q, first_d;
    logic                 pass_q, pass_d;

    logic              last_idx;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_data;
    logic              pipe_push;
    logic              pipe_valid;
    logic [DATA_W-1:0] pipe_exp;
    logic [ADDR_W-1:0] pipe_addr;
    logic              pipe_empty;

    all_things_rd_pipe #(
        .DEPTH  (READ_LATENCY),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (pipe_push),
        .push_exp  (cur_data),
        .push_addr (cur_addr),
        .out_valid (pipe_valid),
        .out_exp   (pipe_exp),
        .out_addr  (pipe_addr),
        .empty     (pipe_empty)
    );

    // Address and data for the current index; the address wraps silently.
    always_comb begin
        cur_addr = base_q + idx_q[ADDR_W-1:0];
        cur_data = seed_q + DATA_W'(idx_q);
        last_idx = (idx_q == len_q - IDX_ONE);
    end

    // Next-state logic, read-back compare and run bookkeeping.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        base_d    = base_q;
        seed_d    = seed_q;
        err_d     = err_q;
        first_d   = first_q;
        pass_d    = pass_q;
        pipe_push = 1'b0;

        // Compare whatever emerges from the pipe, independent of state, so the
        // last few reads are still checked while draining.
        if (pipe_valid && (avm.readdata != pipe_exp)) begin
            if (err_q != '1) err_d = err_q + ERR_ONE;
            if (err_q == '0) first_d = pipe_addr;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    len_d   = length;
                    seed_d  = seed;
                    idx_d   = '0;
                    err_d   = '0;
                    first_d = '0;
                    if (length == '0) begin
                        pass_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        pass_d  = 1'b0;
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (!avm.waitrequest) begin
                    if (last_idx) begin
                        idx_d   = '0;
                        state_d = ST_READ;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end
            ST_READ: begin
                if (!avm.waitrequest) begin
                    pipe_push = 1'b1;
                    if (last_idx) begin
                        state_d = ST_DRAIN;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end
            ST_DRAIN: begin
                // err_d already includes this cycle's compare, so pass is
                // final on entry to DONE.
                if (pipe_empty) begin
                    pass_d  = (err_d == '0);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and run registers; reset returns to IDLE with all results cleared.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            base_q  <= '0;
            seed_q  <= '0;
            err_q   <= '0;
            first_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            base_q  <= base_d;
            seed_q  <= seed_d;
            err_q   <= err_d;
            first_q <= first_d;
            pass_q  <= pass_d;
        end
    end

    // Bus and status outputs decode straight from registered state, so they
    // are stable across stalls and go to zero as soon as reset asserts.
    always_comb begin
        avm.write      = (state_q == ST_WRITE);
        avm.read       = (state_q == ST_READ);
        avm.chipselect = avm.write | avm.read;
        avm.byteenable = '1;
        avm.address    = avm.chipselect ? cur_addr : '0;
        avm.writedata  = avm.write ? cur_data : '0;
        busy           = (state_q != ST_IDLE);
        done           = (state_q == ST_DONE);
        pass           = pass_q;
        err_count      = err_q;
        first_err_addr = first_q;
        dbg_state      = state_q;
    end

endmodule
